// File: rtl/iec_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iec_sd_arbiter
// Purpose  : Round-robin arbiter sharing one host SD block channel among drives.
// Revision : 1.0
// ============================================================================
module iec_sd_arbiter #(
    parameter int  DRIVES  = 2,
    parameter int  TIMEOUT = 2**20,
    localparam int NDR     = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [32*NDR-1:0]    drv_lba,
    input  logic [6*NDR-1:0]     drv_blk_cnt,
    input  logic [NDR-1:0]       drv_rd,
    input  logic [NDR-1:0]       drv_wr,
    output logic [NDR-1:0]       drv_ack,
    input  logic [8*NDR-1:0]     drv_buff_din,
    output logic [31:0]          host_lba,
    output logic [5:0]           host_blk_cnt,
    output logic                 host_rd,
    output logic                 host_wr,
    input  logic                 host_ack,
    output logic [7:0]           host_buff_din,
    output logic [1:0]           grant_idx,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int             TO       = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int             TW       = $clog2(TO + 1);
    localparam logic [TW-1:0]  TMAX     = TW'(TO - 1);
    localparam logic [1:0]     PTR_INIT = 2'(NDR - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [1:0]    ptr;
    logic [TW-1:0] timer;
    logic          abort;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic [2:0]    scan;
    logic          grant_req;

    // Lanes padded to four so every index is a plain 2-bit select.
    logic [31:0] lba_arr  [4];
    logic [5:0]  blk_arr  [4];
    logic [7:0]  buff_arr [4];
    logic [3:0]  rd4, wr4, req4;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        if (i < NDR) begin : g_used
            assign lba_arr[i]  = drv_lba[32*i +: 32];
            assign blk_arr[i]  = drv_blk_cnt[6*i +: 6];
            assign buff_arr[i] = drv_buff_din[8*i +: 8];
            assign rd4[i]      = drv_rd[i];
            assign wr4[i]      = drv_wr[i];
            assign drv_ack[i]  = host_ack & busy & (grant_idx == 2'(i));
        end else begin : g_unused
            assign lba_arr[i]  = 32'h0;
            assign blk_arr[i]  = 6'h0;
            assign buff_arr[i] = 8'h0;
            assign rd4[i]      = 1'b0;
            assign wr4[i]      = 1'b0;
        end
    end

    assign req4      = rd4 | wr4;
    assign grant_req = req4[grant_idx];

    // Scan from the farthest slot back toward ptr+1 so the nearest candidate wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        scan       = 3'd0;
        for (int k = NDR; k >= 1; k--) begin
            scan = {1'b0, ptr} + 3'(k);
            if (scan >= 3'(NDR)) begin
                scan = scan - 3'(NDR);
            end
            if (req4[scan[1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan[1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            S_IDLE: if (pick_valid) state_nxt = S_REQ;
            S_REQ: begin
                if (host_ack) begin
                    state_nxt = S_XFER;
                end else if (!grant_req || timer == TMAX) begin
                    state_nxt = S_GAP;
                    abort     = 1'b1;
                end
            end
            S_XFER: if (!host_ack) state_nxt = S_GAP;
            S_GAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != S_IDLE);
        host_buff_din = busy ? buff_arr[grant_idx] : 8'h00;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            grant_idx    <= 2'd0;
            ptr          <= PTR_INIT;
            host_lba     <= 32'h0;
            host_blk_cnt <= 6'h0;
            host_rd      <= 1'b0;
            host_wr      <= 1'b0;
            timer        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state == S_IDLE && pick_valid) begin
                grant_idx    <= pick_idx;
                ptr          <= pick_idx;
                host_lba     <= lba_arr[pick_idx];
                host_blk_cnt <= blk_arr[pick_idx];
                host_rd      <= rd4[pick_idx];
                host_wr      <= ~rd4[pick_idx];
                timer        <= '0;
            end else begin
                if (state == S_REQ) begin
                    timer <= timer + 1'b1;
                end
                if (state_nxt != S_REQ) begin
                    host_rd <= 1'b0;
                    host_wr <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
